// File: rtl/one_bit_adder.sv
// -----------------------------------------------------------------------------
// one_bit_adder
//   1-bit full adder leaf cell with a registered copy of its outputs and an
//   optional bit-serial mode that reuses the same cell with a carry flop to add
//   two SER_WIDTH-bit operands LSB-first.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   a, b, ci       : adder inputs (ci also seeds the serial carry on ser_start)
//   s, co          : combinational sum / carry (independent of clk and reset)
//   reg_en         : capture enable for s_q / co_q
//   s_q, co_q      : registered sum / carry
//   ser_start      : begin (or restart) a serial add
//   ser_bit_valid  : a/b carry the current serial operand bits
//   ser_busy       : serial add in progress
//   ser_done       : one-cycle pulse after the final bit is consumed
//   ser_sum        : assembled serial sum, bit 0 = first bit added
//   ser_cout       : final carry of the serial add
// -----------------------------------------------------------------------------
module one_bit_adder #(
   parameter int unsigned SER_WIDTH = 4,
   parameter int unsigned CNT_W     = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a,
   input  logic                 b,
   input  logic                 ci,
   output logic                 s,
   output logic                 co,
   input  logic                 reg_en,
   output logic                 s_q,
   output logic                 co_q,
   input  logic                 ser_start,
   input  logic                 ser_bit_valid,
   output logic                 ser_busy,
   output logic                 ser_done,
   output logic [SER_WIDTH-1:0] ser_sum,
   output logic                 ser_cout
);

   localparam int unsigned LAST_IDX = SER_WIDTH - 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Full adder cell: returns {carry, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   state_t               state_q, state_d;
   logic                 carry_q, carry_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SER_WIDTH-1:0] sum_q, sum_d;
   logic                 cout_q, cout_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 ser_s, ser_c;

   // Combinational path: depends only on a, b, ci.
   assign {co, s} = full_add(a, b, ci);

   // Serial cell: same adder with the carry taken from the feedback flop.
   assign {ser_c, ser_s} = full_add(a, b, carry_q);

   // Registered copy of the combinational outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q  <= 1'b0;
         co_q <= 1'b0;
      end else if (reg_en) begin
         s_q  <= s;
         co_q <= co;
      end
   end

   // Serial state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Serial next-state logic; ser_start takes priority over a final bit.
   always_comb begin
      state_d = state_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (ser_start) begin
               state_d = RUN;
               carry_d = ci;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (ser_start) begin
               carry_d = ci;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               busy_d  = 1'b1;
            end else if (ser_bit_valid) begin
               carry_d = ser_c;
               sum_d   = {ser_s, sum_q[SER_WIDTH-1:1]};
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(LAST_IDX)) begin
                  cout_d  = ser_c;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ser_busy = busy_q;
   assign ser_done = done_q;
   assign ser_sum  = sum_q;
   assign ser_cout = cout_q;

endmodule

// File: tb/tb_one_bit_adder.sv
// -----------------------------------------------------------------------------
// tb_one_bit_adder
//   Scoreboard bench for one_bit_adder (SER_WIDTH = 4). Expected results are
//   pushed when stimulus is driven and popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_one_bit_adder;

   localparam int unsigned SW = 4;

   logic          clk;
   logic          rst_n;
   logic          a, b, ci;
   logic          s, co;
   logic          reg_en;
   logic          s_q, co_q;
   logic          ser_start, ser_bit_valid;
   logic          ser_busy, ser_done;
   logic [SW-1:0] ser_sum;
   logic          ser_cout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [SW-1:0] sum;
      logic          cout;
   } ser_exp_t;

   logic [1:0] comb_q[$];   // {co, s}
   logic [1:0] reg_q[$];    // {co_q, s_q}
   ser_exp_t   ser_q[$];

   one_bit_adder #(.SER_WIDTH(SW), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .s(s), .co(co),
      .reg_en(reg_en), .s_q(s_q), .co_q(co_q),
      .ser_start(ser_start), .ser_bit_valid(ser_bit_valid),
      .ser_busy(ser_busy), .ser_done(ser_done),
      .ser_sum(ser_sum), .ser_cout(ser_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_comb();
      logic [2:0] v;
      logic [1:0] exp_v;
      for (int r = 0; r < 2; r++) begin
         rst_n = r[0];
         for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, ci} = v;
            comb_q.push_back({2'((int'(v[2]) + int'(v[1]) + int'(v[0])) >= 2), v[2] ^ v[1] ^ v[0]});
            #1;
            exp_v = comb_q.pop_front();
            checks++;
            if ({co, s} !== exp_v) begin
               errors++;
               $display("FAIL comb rst_n=%0d abc=%b got co,s=%b exp %b", r, v, {co, s}, exp_v);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s_q, co_q, ser_busy, ser_done, ser_sum, ser_cout} !== '0) begin
         errors++;
         $display("FAIL reset_state got s_q=%b co_q=%b busy=%b done=%b sum=%b cout=%b exp all 0",
                  s_q, co_q, ser_busy, ser_done, ser_sum, ser_cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_registered();
      logic [1:0] exp_v;
      a = 1'b1; b = 1'b0; ci = 1'b1; reg_en = 1'b1;
      reg_q.push_back(2'b10);
      tick();
      exp_v = reg_q.pop_front();
      checks++;
      if ({co_q, s_q} !== exp_v) begin
         errors++;
         $display("FAIL reg_capture got co_q,s_q=%b exp %b", {co_q, s_q}, exp_v);
      end
      reg_en = 1'b0; a = 1'b1; b = 1'b1; ci = 1'b1;
      reg_q.push_back(2'b10);
      tick(); tick();
      exp_v = reg_q.pop_front();
      checks++;
      if ({co_q, s_q} !== exp_v) begin
         errors++;
         $display("FAIL reg_hold got co_q,s_q=%b exp %b", {co_q, s_q}, exp_v);
      end
      reg_en = 1'b1; a = 1'b0; b = 1'b0; ci = 1'b1;
      reg_q.push_back(2'b01);
      tick();
      exp_v = reg_q.pop_front();
      checks++;
      if ({co_q, s_q} !== exp_v) begin
         errors++;
         $display("FAIL reg_recapture got co_q,s_q=%b exp %b", {co_q, s_q}, exp_v);
      end
      reg_en = 1'b0;
   endtask

   task automatic ser_begin(input logic cin);
      ser_start = 1'b1; ci = cin; ser_bit_valid = 1'b0;
      tick();
      ser_start = 1'b0;
      checks++;
      if (ser_busy !== 1'b1 || ser_sum !== '0) begin
         errors++;
         $display("FAIL ser_begin got busy=%b sum=%b exp busy=1 sum=0", ser_busy, ser_sum);
      end
   endtask

   // Feeds x/y LSB-first (stalling before bit i when stalls[i]) and checks
   // the result against the arithmetic sum x + y + cin.
   task automatic serial_body(input logic [SW-1:0] x, input logic [SW-1:0] y,
                              input logic cin, input logic [SW-1:0] stalls);
      ser_exp_t e;
      int       total;
      int       waited;
      total = int'(x) + int'(y) + int'(cin);
      e.sum  = SW'(total);
      e.cout = 1'(total >> SW);
      ser_q.push_back(e);
      for (int i = 0; i < int'(SW); i++) begin
         if (stalls[i]) begin
            ser_bit_valid = 1'b0;
            a = 1'($urandom_range(1)); b = 1'($urandom_range(1));
            tick();
            checks++;
            if (ser_busy !== 1'b1 || ser_done !== 1'b0) begin
               errors++;
               $display("FAIL ser_stall bit=%0d got busy=%b done=%b exp busy=1 done=0", i, ser_busy, ser_done);
            end
         end
         ser_bit_valid = 1'b1; a = x[i]; b = y[i];
         tick();
         if (i < int'(SW) - 1) begin
            checks++;
            if (ser_busy !== 1'b1 || ser_done !== 1'b0) begin
               errors++;
               $display("FAIL ser_run bit=%0d got busy=%b done=%b exp busy=1 done=0", i, ser_busy, ser_done);
            end
         end
      end
      ser_bit_valid = 1'b0;
      waited = 0;
      while (ser_done !== 1'b1 && waited < 4) begin
         tick();
         waited++;
      end
      e = ser_q.pop_front();
      checks++;
      if (waited != 0 || ser_done !== 1'b1 || ser_busy !== 1'b0) begin
         errors++;
         $display("FAIL ser_done_timing got done=%b busy=%b after %0d extra cycles exp done=1 busy=0 at once",
                  ser_done, ser_busy, waited);
      end
      checks++;
      if (ser_sum !== e.sum || ser_cout !== e.cout) begin
         errors++;
         $display("FAIL ser_result got sum=%b cout=%b exp sum=%b cout=%b", ser_sum, ser_cout, e.sum, e.cout);
      end
      tick();
      checks++;
      if (ser_done !== 1'b0 || ser_sum !== e.sum || ser_cout !== e.cout) begin
         errors++;
         $display("FAIL ser_pulse_hold got done=%b sum=%b cout=%b exp done=0 sum=%b cout=%b",
                  ser_done, ser_sum, ser_cout, e.sum, e.cout);
      end
   endtask

   task automatic test_serial_basic();
      ser_begin(1'b0);
      serial_body(4'b1011, 4'b0110, 1'b0, 4'b0000);
   endtask

   task automatic test_serial_stall();
      ser_begin(1'b1);
      serial_body(4'b0011, 4'b0100, 1'b1, 4'b1010);
   endtask

   task automatic test_abort();
      ser_begin(1'b0);
      ser_bit_valid = 1'b1; a = 1'b1; b = 1'b1;
      tick(); tick();
      // restart while in RUN with a different carry-in
      ser_begin(1'b1);
      serial_body(4'b1001, 4'b1001, 1'b1, 4'b0000);
   endtask

   task automatic test_start_on_last_bit();
      ser_begin(1'b1);
      ser_bit_valid = 1'b1; a = 1'b1; b = 1'b1;
      tick(); tick(); tick();
      ser_start = 1'b1; ci = 1'b0;
      tick();
      ser_start = 1'b0; ser_bit_valid = 1'b0;
      checks++;
      if (ser_done !== 1'b0 || ser_busy !== 1'b1 || ser_sum !== '0 || ser_cout !== 1'b0) begin
         errors++;
         $display("FAIL start_beats_last got done=%b busy=%b sum=%b cout=%b exp done=0 busy=1 sum=0 cout=0",
                  ser_done, ser_busy, ser_sum, ser_cout);
      end
      serial_body(4'b0111, 4'b1000, 1'b0, 4'b0100);
   endtask

   task automatic test_reset_mid();
      reg_en = 1'b1; a = 1'b1; b = 1'b0; ci = 1'b0;
      tick();
      reg_en = 1'b0;
      ser_begin(1'b0);
      ser_bit_valid = 1'b1; a = 1'b1; b = 1'b0;
      tick();
      a = 1'b0; b = 1'b0;
      tick();
      checks++;
      if (s_q !== 1'b1 || ser_sum !== 4'b0100 || ser_busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset got s_q=%b sum=%b busy=%b exp s_q=1 sum=0100 busy=1", s_q, ser_sum, ser_busy);
      end
      #2;
      a = 1'b1; b = 1'b1; ci = 1'b0;
      comb_q.push_back(2'b10);
      rst_n = 1'b0;
      #1;
      checks++;
      if (s_q !== 1'b0 || ser_busy !== 1'b0 || ser_sum !== '0 || ser_cout !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got s_q=%b busy=%b sum=%b cout=%b exp all 0", s_q, ser_busy, ser_sum, ser_cout);
      end
      checks++;
      if ({co, s} !== comb_q.pop_front()) begin
         errors++;
         $display("FAIL comb_in_reset got co,s=%b exp 10", {co, s});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ser_done !== 1'b0 || ser_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset cyc=%0d got done=%b busy=%b exp done=0 busy=0", i, ser_done, ser_busy);
         end
      end
      ser_bit_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; a = 1'b0; b = 1'b0; ci = 1'b0;
      reg_en = 1'b0; ser_start = 1'b0; ser_bit_valid = 1'b0;
      test_comb();
      test_reset();
      test_registered();
      test_serial_basic();
      test_serial_stall();
      test_abort();
      test_start_on_last_bit();
      test_reset_mid();
      test_serial_basic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/one_bit_adder.md
Name: one_bit_adder

Overview:
- 1-bit full adder with a purely combinational sum/carry path (a, b, ci -> s, co).
- Registered copy of s/co for pipeline use.
- Optional bit-serial mode: the same adder cell, with its carry fed back through a flop, adds two SER_WIDTH-bit operands LSB-first over SER_WIDTH cycles and assembles the result in a shift register.
- Used as the leaf cell of the ripple adders and as a low-area serial adder.

Parameters:
- SER_WIDTH, 4, operand width in bits for serial mode (2..32).
- CNT_W, 6, width of the serial bit counter; must satisfy 2^CNT_W > SER_WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a  in  1  addend bit
- b  in  1  addend bit
- ci  in  1  carry in (combinational path); initial carry for serial mode
- s  out  1  combinational sum, a^b^ci
- co  out  1  combinational carry, (a&b)|(a&ci)|(b&ci)
- reg_en  in  1  capture enable for s_q/co_q
- s_q  out  1  registered s
- co_q  out  1  registered co
- ser_start  in  1  begin serial add: load carry flop from ci, clear counter and sum register
- ser_bit_valid  in  1  a/b hold the current serial operand bits
- ser_busy  out  1  serial operation in progress
- ser_done  out  1  one-cycle pulse when the final bit has been consumed
- ser_sum  out  SER_WIDTH  assembled sum, LSB first in time, stable after ser_done
- ser_cout  out  1  final carry out of the serial add

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous, active-low (rst_n).
- Combinational path: s and co depend only on a, b, ci.
  - They never depend on clk, rst_n or any serial-mode state, including during reset.
  - Zero latency.
- Registered outputs:
  - At each rising clk with reg_en=1, s_q<=s and co_q<=co; otherwise they hold.
  - Latency is one cycle.
- Reset (rst_n=0, asynchronous): s_q=0, co_q=0, carry flop=0, counter=0, ser_busy=0, ser_done=0, ser_sum=0, ser_cout=0.
- Serial state machine, states IDLE and RUN:
  - IDLE, ser_start=1: carry flop<=ci, counter<=0, ser_sum<=0, ser_busy<=1, go to RUN.
  - RUN, ser_bit_valid=1: the serial cell computes a^b^carry and the majority carry.
    - The sum bit is shifted into ser_sum from the MSB end (ser_sum <= {bit, ser_sum[SER_WIDTH-1:1]}).
    - carry flop <= new carry; counter increments.
  - RUN, ser_bit_valid=0: everything holds (stall).
  - When the counter reaches SER_WIDTH-1 with ser_bit_valid=1:
    - ser_cout<=new carry, ser_done=1 for exactly the next cycle, ser_busy<=0, return to IDLE.
    - After ser_done, ser_sum holds the full result with bit 0 = first bit added.
  - ser_start in RUN aborts and restarts: carry flop reloads from ci, counter, ser_sum, ser_done and ser_cout clear, state stays RUN.
  - ser_start and the final bit in the same cycle: ser_start wins; no ser_done is produced.
  - ser_bit_valid in IDLE is ignored.
- Reset mid-operation: immediate return to IDLE with all state cleared; s and co are unaffected.
- Output hold rules:
  - ser_sum and ser_cout hold their values until the next ser_start or reset.
  - ser_done is never asserted while ser_busy=1.

Test Plan:
- Exhaustive combinational: all 8 {a,b,ci} combinations, e.g. a=1,b=1,ci=0 -> s=0,co=1; a=1,b=1,ci=1 -> s=1,co=1; 0,0,0 -> s=0,co=0; check within the same timestep, with rst_n both 0 and 1.
- Registered path: a=1,b=0,ci=1 with reg_en=1 -> s_q=0,co_q=1 one clk later; drop reg_en and change inputs -> s_q/co_q hold.
- Serial add (SER_WIDTH=4): 0b1011 + 0b0110, ci=0, bits fed LSB-first on 4 consecutive valid cycles -> ser_done pulse, ser_sum=0b0001, ser_cout=1.
- Serial with stalls and ci=1: 0b0011 + 0b0100, ci=1, with ser_bit_valid gaps -> ser_sum=0b1000, ser_cout=0; ser_busy high throughout.
- Abort and reset: ser_start mid-operation restarts cleanly and yields the correct sum; rst_n=0 asserted between clock edges immediately clears s_q, ser_busy and ser_sum, and no ser_done follows.
